// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b000_0000;
  localparam logic [6:0] SEG_ZERO  = 7'b111_1110;

  // Register width for a counter over 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Register-side controls and board-side display pins of the scan controller.
interface seg_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);
  logic                  en;
  logic                  load;
  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   digit_sel;
  logic [6:0]            seg;
  logic                  dp;
  logic                  frame_done;

  modport master (
    output en, load, value, dp_in,
    input  digit_sel, seg, dp, frame_done
  );

  modport slave (
    input  en, load, value, dp_in,
    output digit_sel, seg, dp, frame_done
  );
endinterface

// File: rtl/hex_seg_decode.sv
// Hex nibble to seven-segment pattern, {a,b,c,d,e,f,g}, active-high.
module hex_seg_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Full 16-entry lookup; lowercase b and d keep them distinct from 8 and 0.
  always_comb begin
    // NOTE: a default before the case means every path assigns seg, so no latch is inferred.
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = SEG_ZERO;
      4'h1: seg = 7'b011_0000;
      4'h2: seg = 7'b110_1101;
      4'h3: seg = 7'b111_1001;
      4'h4: seg = 7'b011_0011;
      4'h5: seg = 7'b101_1011;
      4'h6: seg = 7'b101_1111;
      4'h7: seg = 7'b111_0000;
      4'h8: seg = 7'b111_1111;
      4'h9: seg = 7'b111_1011;
      4'hA: seg = 7'b111_0111;
      4'hB: seg = 7'b001_1111;
      4'hC: seg = 7'b100_1110;
      4'hD: seg = 7'b011_1101;
      4'hE: seg = 7'b100_1111;
      4'hF: seg = 7'b100_0111;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a double-buffered
// display value and a blanking guard at the start of every digit slot.
// Optional build macro: SEGSCAN_LZS_EN enables leading-zero suppression.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       reset,
  seg_scan_ctrl_if.slave bus
);

  localparam int CNT_W = width_of(PRESCALE);
  localparam int IDX_W = width_of(N_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
  // With no blanking guard a slot begins directly in SHOW.
  localparam state_e SLOT_START = (BLANK_CYC == 0) ? SHOW : BLANK;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] act_val_q, act_val_d;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [4*N_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                  pending_valid_q, pending_valid_d;
  logic [N_DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic                  dp_q, dp_d;
  logic [3:0]            hex_q, hex_d;
  logic                  frame_done_q, frame_done_d;
  logic                  boundary;
  logic                  suppress;

  function automatic logic [3:0] nibble_at(input logic [4*N_DIGITS-1:0] v,
                                           input logic [IDX_W-1:0]      i);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (i == IDX_W'(k)) r = v[4*k +: 4];
    end
    return r;
  endfunction

  function automatic logic bit_at(input logic [N_DIGITS-1:0] v,
                                  input logic [IDX_W-1:0]    i);
    logic r;
    r = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (i == IDX_W'(k)) r = v[k];
    end
    return r;
  endfunction

  // Slot sequencing: cnt runs 0..PRESCALE-1 across BLANK then SHOW, idx steps per slot.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    boundary = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SLOT_START;
          cnt_d   = '0;
          idx_d   = '0;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = SHOW;
        end
        SHOW: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = SLOT_START;
            if (idx_q == IDX_LAST) begin
              idx_d    = '0;
              boundary = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Double buffer: loads park in pending and are promoted only between frames.
  always_comb begin
    act_val_d       = act_val_q;
    act_dp_d        = act_dp_q;
    pend_val_d      = pend_val_q;
    pend_dp_d       = pend_dp_q;
    pending_valid_d = pending_valid_q;
    if (bus.load && (!bus.en || boundary)) begin
      // No frame in flight (or one just ended): take the new value directly.
      act_val_d       = bus.value;
      act_dp_d        = bus.dp_in;
      pend_val_d      = bus.value;
      pend_dp_d       = bus.dp_in;
      pending_valid_d = 1'b0;
    end else if (bus.load) begin
      pend_val_d      = bus.value;
      pend_dp_d       = bus.dp_in;
      pending_valid_d = 1'b1;
    end else if (boundary && pending_valid_q) begin
      act_val_d       = pend_val_q;
      act_dp_d        = pend_dp_q;
      pending_valid_d = 1'b0;
    end
  end

`ifdef SEGSCAN_LZS_EN
  logic [N_DIGITS-1:0] lz_mask;

  // Mark digits lying above the most significant nonzero nibble that carry no dp.
  always_comb begin
    logic upper_zero;
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (act_val_d[4*k +: 4] == 4'd0);
      lz_mask[k] = upper_zero && !act_dp_d[k];
    end
  end

  assign suppress = bit_at(lz_mask, idx_d);
`else
  assign suppress = 1'b0;
`endif

  // Registered pin drive, computed from the upcoming state so pins line up with it.
  always_comb begin
    digit_sel_d  = '0;
    dp_d         = 1'b0;
    hex_d        = nibble_at(act_val_d, idx_d);
    frame_done_d = boundary;
    if (state_d == SHOW) begin
      dp_d = bit_at(act_dp_d, idx_d);
      if (!suppress) digit_sel_d = N_DIGITS'(1) << idx_d;
    end
  end

  // State, buffers and output registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking only, so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      act_val_q       <= '0;
      act_dp_q        <= '0;
      pend_val_q      <= '0;
      pend_dp_q       <= '0;
      pending_valid_q <= 1'b0;
      digit_sel_q     <= '0;
      dp_q            <= 1'b0;
      hex_q           <= 4'd0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      act_val_q       <= act_val_d;
      act_dp_q        <= act_dp_d;
      pend_val_q      <= pend_val_d;
      pend_dp_q       <= pend_dp_d;
      pending_valid_q <= pending_valid_d;
      digit_sel_q     <= digit_sel_d;
      dp_q            <= dp_d;
      hex_q           <= hex_d;
      frame_done_q    <= frame_done_d;
    end
  end

  hex_seg_decode u_decode (
    .hex (hex_q),
    .seg (bus.seg)
  );

  assign bus.digit_sel  = digit_sel_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an N-digit common-anode-style seven-segment display bank.
- One shared hex-to-seven-segment decoder drives all digits; the block selects one digit at a time and feeds it that digit's nibble.
- Double-buffers the display value, with a blanking guard between digits to prevent ghosting.
- Sits between the system register interface and the board-level display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned; legal range 1..8.
- PRESCALE, 50000, clk cycles per digit slot, including blank; must be > BLANK_CYC.
- BLANK_CYC, 500, cycles at the start of each slot with all digit selects off; legal range 0..PRESCALE-1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  scan enable; 0 = display dark, scan frozen at digit 0
- load  input  1  one-cycle strobe; captures value/dp_in into the pending buffer
- value  input  4*N_DIGITS  hex nibbles; digit i = value[4i+3:4i], digit 0 rightmost
- dp_in  input  N_DIGITS  decimal point per digit
- digit_sel  output  N_DIGITS  one-hot digit enable, active-high; all-zero when dark or blanking
- seg  output  7  segments {a,b,c,d,e,f,g}, MSB = a, active-high
- dp  output  1  decimal point for the selected digit
- frame_done  output  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Registers: active buffer (value + dp), pending buffer, pending_valid flag, prescale counter cnt (width clog2(PRESCALE)), digit index idx (width clog2(N_DIGITS), minimum 1), FSM state.
- Reset values:
  - state IDLE; cnt = 0; idx = 0; both buffers = 0; pending_valid = 0.
  - digit_sel = 0, dp = 0, frame_done = 0.
  - seg = decode(0) = 7'b111_1110, dark because digit_sel = 0.
- FSM states:
  - IDLE: digit_sel = 0; cnt and idx held at 0. en = 1 moves to BLANK (or SHOW if BLANK_CYC = 0) on the next edge with cnt = 0.
  - BLANK: digit_sel = 0. hex is loaded with nibble idx so the decoder settles before drive. Leaves for SHOW when cnt = BLANK_CYC-1.
  - SHOW: digit_sel = 1<<idx; seg = decode(nibble idx); dp = active dp[idx]. At cnt = PRESCALE-1:
    - cnt wraps to 0;
    - idx advances, wrapping N_DIGITS-1 → 0;
    - next state is BLANK (or SHOW if BLANK_CYC = 0).
- en deasserted in any state: next edge goes to IDLE; cnt and idx are cleared and the display goes dark. No partial-slot completion.
- Frame boundary is the SHOW, idx = N_DIGITS-1, cnt = PRESCALE-1 cycle:
  - frame_done is asserted for exactly that cycle (registered, visible the following cycle).
  - If pending_valid, pending is copied to active and pending_valid is cleared.
- Load rules:
  - load = 1 copies value/dp_in to pending and sets pending_valid; the latest load wins.
  - load on the boundary cycle itself: the incoming value goes straight to active and pending_valid ends 0.
  - load while en = 0: commit happens immediately, since no frame is in progress.
- Outputs digit_sel, dp and hex are registered. seg is combinational from the registered hex through the decoder.
- Latency from en rise to first lit digit: BLANK_CYC+1 cycles.

Optional Feature:
Macro: SEGSCAN_LZS_EN
- Defined: leading-zero suppression is active.
  - Any digit above the most significant nonzero nibble in active, with its dp = 0, is forced dark: digit_sel bit stays 0 during its SHOW slot.
  - Digit 0 is never suppressed; an all-zero value displays "0".
  - Slot timing is unchanged.
- Undefined: all digits are always driven; no suppression logic is synthesised.

Decomposition:
- Package seg_scan_pkg:
  - state enum typedef {IDLE, BLANK, SHOW};
  - segment constants SEG_BLANK = 7'b000_0000 and SEG_ZERO = 7'b111_1110.
- Sub-module hex_seg_decode: pure combinational 4-bit → 7-bit hex decoder, 0–9 and A–F, abc_defg ordering.
  - 3 = 7'b111_1001; A = 7'b111_0111; b = 7'b001_1111; F = 7'b100_0111.
  - Instantiated once and shared across all digits.

Test Plan (N_DIGITS=4, PRESCALE=8, BLANK_CYC=2 unless noted):
- Reset mid-SHOW:
  - Stimulus: assert reset asynchronously.
  - Response: digit_sel = 0, dp = 0, frame_done = 0 immediately, without waiting for a clk edge; after release, first digit_sel = 4'b0001 at cycle 3 after en.
- Scan sequence:
  - Stimulus: load value = 16'h3A0F, en = 1.
  - Response: digit_sel walks 0001 → 0010 → 0100 → 1000 with seg 7'b100_0111, 7'b111_1110, 7'b111_0111, 7'b111_1001; each lit for 6 cycles with 2 dark cycles between; frame_done pulses every 32 cycles.
- Double buffer:
  - Stimulus: load 16'h1111 at mid-frame, then 16'h2222 one cycle later.
  - Response: the current frame finishes unchanged; the next frame shows 2 on every digit; 1111 is never displayed.
- Boundary load:
  - Stimulus: load 16'h0005 on the frame_done cycle.
  - Response: the next frame's digit 0 shows 7'b101_1011; pending_valid = 0.
- en drop:
  - Stimulus: deassert en during digit 2 SHOW.
  - Response: digit_sel = 0 on the next edge; on re-enable, scan restarts at digit 0.
- SEGSCAN_LZS_EN:
  - Stimulus: value = 16'h0040, dp_in = 0.
  - Response: digits 3 and 2 dark, digits 1 and 0 show 4 and 0.
  - Stimulus: value = 16'h0000.
  - Response: only digit 0 is lit, showing 0.
